// File: rtl/cordic_share_arbiter.sv
// Round-robin arbiter sharing one iterative CORDIC core between two channels.
// Optional WAIT watchdog: define CORDIC_SHARE_ARBITER_TIMEOUT_EN.
module cordic_share_arbiter #(
  parameter int DATA_W         = 10,
  parameter int TIMEOUT_CYCLES = 31,
  parameter int CNT_W          = 5
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              ch0_req_valid_i,
  output logic              ch0_req_ready_o,
  input  logic [DATA_W-1:0] ch0_angle_i,
  input  logic [DATA_W-1:0] ch0_amp_i,
  output logic              ch0_rsp_valid_o,
  output logic [DATA_W-1:0] ch0_cos_o,
  output logic [DATA_W-1:0] ch0_sin_o,
  input  logic              ch1_req_valid_i,
  output logic              ch1_req_ready_o,
  input  logic [DATA_W-1:0] ch1_angle_i,
  input  logic [DATA_W-1:0] ch1_amp_i,
  output logic              ch1_rsp_valid_o,
  output logic [DATA_W-1:0] ch1_cos_o,
  output logic [DATA_W-1:0] ch1_sin_o,
  output logic              rsp_err_o,
  output logic              cordic_strb_o,
  output logic [DATA_W-1:0] cordic_X_o,
  output logic [DATA_W-1:0] cordic_Y_o,
  output logic [DATA_W-1:0] cordic_Z_o,
  input  logic              cordic_strb_i,
  input  logic [DATA_W-1:0] cordic_X_i,
  input  logic [DATA_W-1:0] cordic_Y_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER} state_t;

  state_t            r_state, w_next;
  logic              r_rr, r_owner;
  logic [DATA_W-1:0] r_x, r_z;
  logic [DATA_W-1:0] r_cos0, r_sin0, r_cos1, r_sin1;
  logic              w_gnt0, w_gnt1, w_hs, w_done, w_tmo;

  if (TIMEOUT_CYCLES >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  // rr_ptr only breaks ties; a lone requester always wins.
  assign w_gnt0 = ch0_req_valid_i & (~ch1_req_valid_i | ~r_rr);
  assign w_gnt1 = ch1_req_valid_i & (~ch0_req_valid_i |  r_rr);
  assign w_hs   = (r_state == S_IDLE) & (w_gnt0 | w_gnt1);
  assign w_done = (r_state == S_WAIT) & cordic_strb_i;

`ifdef CORDIC_SHARE_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  // A done strobe on the final count still wins over the abort.
  assign w_tmo = (r_state == S_WAIT) & ~cordic_strb_i &
                 (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (w_done)     r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
    end
  end

  assign rsp_err_o = r_err & (r_state == S_DELIVER);
`else
  assign w_tmo     = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_hs) w_next = S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (w_done || w_tmo) w_next = S_DELIVER;
      S_DELIVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_owner <= 1'b0;
      r_x     <= '0;
      r_z     <= '0;
      r_cos0  <= '0;
      r_sin0  <= '0;
      r_cos1  <= '0;
      r_sin1  <= '0;
    end else begin
      r_state <= w_next;
      if (w_hs) begin
        r_owner <= w_gnt1;
        r_x     <= w_gnt1 ? ch1_amp_i   : ch0_amp_i;
        r_z     <= w_gnt1 ? ch1_angle_i : ch0_angle_i;
      end
      if (w_done) begin
        if (r_owner) begin
          r_cos1 <= cordic_X_i;
          r_sin1 <= cordic_Y_i;
        end else begin
          r_cos0 <= cordic_X_i;
          r_sin0 <= cordic_Y_i;
        end
      end
      if (r_state == S_DELIVER) r_rr <= ~r_owner;
    end
  end

  // Readys are gated by reset so nothing is accepted while held in reset.
  assign ch0_req_ready_o = rstn_i & (r_state == S_IDLE) & w_gnt0;
  assign ch1_req_ready_o = rstn_i & (r_state == S_IDLE) & w_gnt1;
  assign ch0_rsp_valid_o = (r_state == S_DELIVER) & ~r_owner;
  assign ch1_rsp_valid_o = (r_state == S_DELIVER) &  r_owner;
  assign ch0_cos_o       = r_cos0;
  assign ch0_sin_o       = r_sin0;
  assign ch1_cos_o       = r_cos1;
  assign ch1_sin_o       = r_sin1;
  assign cordic_strb_o   = (r_state == S_ISSUE);
  assign cordic_X_o      = r_x;
  assign cordic_Y_o      = '0;
  assign cordic_Z_o      = r_z;
  assign busy_o          = (r_state != S_IDLE);

endmodule
